// File: rtl/dda_stepper_v2.sv
// 3D DDA voxel traversal engine: walks the grid from a start voxel until it
// hits a solid voxel, leaves the grid, runs out of steps, passes t_max or is aborted.
module dda_stepper_v2 #(
  parameter int W           = 24,
  parameter int IDX_BITS    = 5,
  parameter int STEP_BITS   = 10,
  parameter int RD_LAT      = 1,
  parameter int CHECK_START = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  job_valid,
  output logic                  job_ready,
  input  logic [IDX_BITS-1:0]   ix0,
  input  logic [IDX_BITS-1:0]   iy0,
  input  logic [IDX_BITS-1:0]   iz0,
  input  logic                  sx,
  input  logic                  sy,
  input  logic                  sz,
  input  logic [W-1:0]          next_x_init,
  input  logic [W-1:0]          next_y_init,
  input  logic [W-1:0]          next_z_init,
  input  logic [W-1:0]          inc_x,
  input  logic [W-1:0]          inc_y,
  input  logic [W-1:0]          inc_z,
  input  logic [W-1:0]          t_max,
  input  logic [STEP_BITS-1:0]  max_steps,
  input  logic                  abort,
  output logic                  busy,
  output logic [3*IDX_BITS-1:0] voxel_addr,
  input  logic                  voxel_solid,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic                  hit,
  output logic [IDX_BITS-1:0]   hx,
  output logic [IDX_BITS-1:0]   hy,
  output logic [IDX_BITS-1:0]   hz,
  output logic [2:0]            face_id,
  output logic [W-1:0]          t_hit,
  output logic [STEP_BITS-1:0]  steps_taken,
  output logic [2:0]            status
);

  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CW-1:0] LAT_LOAD = (RD_LAT > 0) ? CW'(RD_LAT - 1) : '0;
  localparam logic [2:0] ST_HIT = 3'd0, ST_OOB = 3'd1, ST_MAXSTEP = 3'd2,
                         ST_TMAX = 3'd3, ST_ABORT = 3'd4;
  localparam logic [2:0] FACE_NONE = 3'd7;

  typedef enum logic [2:0] {S_IDLE, S_STEP, S_ISSUE, S_CHECK, S_RESULT} state_t;

  state_t               state_reg;
  state_t               after_addr;
  logic [IDX_BITS-1:0]  pos_reg   [3];
  logic [W-1:0]         timer_reg [3];
  logic [W-1:0]         inc_reg   [3];
  logic [W-1:0]         timer_sat [3];
  logic [2:0]           sgn_reg;
  logic [W-1:0]         t_max_reg;
  logic [W-1:0]         t_cur_reg;
  logic [STEP_BITS-1:0] max_steps_reg;
  logic [STEP_BITS-1:0] step_cnt_reg;
  logic [2:0]           face_reg;
  logic [CW-1:0]        lat_cnt_reg;

  logic [1:0]           sel;
  logic [W-1:0]         sel_timer;
  logic [IDX_BITS-1:0]  sel_pos;
  logic                 sel_sgn;
  logic                 at_edge;
  logic                 fin;
  logic                 fin_hit;
  logic [2:0]           fin_status;

  assign job_ready  = (state_reg == S_IDLE);
  assign busy       = (state_reg != S_IDLE);
  assign voxel_addr = {pos_reg[2], pos_reg[1], pos_reg[0]};
  assign after_addr = (RD_LAT == 0) ? S_CHECK : S_ISSUE;

  // Per-axis timer advance saturates instead of wrapping so a far boundary never looks near.
  for (genvar gi = 0; gi < 3; gi++) begin : g_axis
    logic [W:0] sum;
    assign sum           = {1'b0, timer_reg[gi]} + {1'b0, inc_reg[gi]};
    assign timer_sat[gi] = sum[W] ? {W{1'b1}} : sum[W-1:0];
  end

  // Minimum-timer axis; ties go to X, then Y.
  always_comb begin
    sel = 2'd2;
    if (timer_reg[0] <= timer_reg[1] && timer_reg[0] <= timer_reg[2]) sel = 2'd0;
    else if (timer_reg[1] <= timer_reg[2])                             sel = 2'd1;
    sel_timer = timer_reg[2];
    sel_pos   = pos_reg[2];
    sel_sgn   = sgn_reg[2];
    if (sel == 2'd0) begin
      sel_timer = timer_reg[0];
      sel_pos   = pos_reg[0];
      sel_sgn   = sgn_reg[0];
    end else if (sel == 2'd1) begin
      sel_timer = timer_reg[1];
      sel_pos   = pos_reg[1];
      sel_sgn   = sgn_reg[1];
    end
    at_edge = sel_sgn ? (sel_pos == {IDX_BITS{1'b1}}) : (sel_pos == '0);
  end

  always_comb begin
    fin        = 1'b0;
    fin_hit    = 1'b0;
    fin_status = ST_HIT;
    case (state_reg)
      S_STEP: begin
        fin = 1'b1;
        if (abort)                          fin_status = ST_ABORT;
        else if (step_cnt_reg == max_steps_reg) fin_status = ST_MAXSTEP;
        else if (at_edge)                   fin_status = ST_OOB;
        else if (sel_timer > t_max_reg)     fin_status = ST_TMAX;
        else                                fin = 1'b0;
      end
      S_ISSUE: begin
        fin        = abort;
        fin_status = ST_ABORT;
      end
      S_CHECK: begin
        if (abort) begin
          fin        = 1'b1;
          fin_status = ST_ABORT;
        end else if (voxel_solid) begin
          fin     = 1'b1;
          fin_hit = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= S_IDLE;
      for (int a = 0; a < 3; a++) begin
        pos_reg[a]   <= '0;
        timer_reg[a] <= '0;
        inc_reg[a]   <= '0;
      end
      sgn_reg       <= '0;
      t_max_reg     <= '0;
      t_cur_reg     <= '0;
      max_steps_reg <= '0;
      step_cnt_reg  <= '0;
      face_reg      <= FACE_NONE;
      lat_cnt_reg   <= '0;
      res_valid     <= 1'b0;
      hit           <= 1'b0;
      hx            <= '0;
      hy            <= '0;
      hz            <= '0;
      face_id       <= FACE_NONE;
      t_hit         <= '0;
      steps_taken   <= '0;
      status        <= '0;
    end else if (fin) begin
      // Result fields are captured once here and held untouched through RESULT.
      state_reg   <= S_RESULT;
      res_valid   <= 1'b1;
      hit         <= fin_hit;
      status      <= fin_status;
      hx          <= pos_reg[0];
      hy          <= pos_reg[1];
      hz          <= pos_reg[2];
      face_id     <= face_reg;
      t_hit       <= t_cur_reg;
      steps_taken <= step_cnt_reg;
    end else begin
      case (state_reg)
        S_IDLE: if (job_valid) begin
          pos_reg[0]    <= ix0;
          pos_reg[1]    <= iy0;
          pos_reg[2]    <= iz0;
          timer_reg[0]  <= next_x_init;
          timer_reg[1]  <= next_y_init;
          timer_reg[2]  <= next_z_init;
          inc_reg[0]    <= inc_x;
          inc_reg[1]    <= inc_y;
          inc_reg[2]    <= inc_z;
          sgn_reg       <= {sz, sy, sx};
          t_max_reg     <= t_max;
          max_steps_reg <= max_steps;
          step_cnt_reg  <= '0;
          t_cur_reg     <= '0;
          face_reg      <= FACE_NONE;
          lat_cnt_reg   <= LAT_LOAD;
          state_reg     <= (CHECK_START != 0) ? after_addr : S_STEP;
        end
        S_STEP: begin
          for (int a = 0; a < 3; a++) begin
            if (sel == 2'(a)) begin
              pos_reg[a]   <= sel_sgn ? pos_reg[a] + 1'b1 : pos_reg[a] - 1'b1;
              timer_reg[a] <= timer_sat[a];
            end
          end
          t_cur_reg    <= sel_timer;
          step_cnt_reg <= step_cnt_reg + 1'b1;
          face_reg     <= {sel, ~sel_sgn};
          lat_cnt_reg  <= LAT_LOAD;
          state_reg    <= after_addr;
        end
        S_ISSUE: begin
          if (lat_cnt_reg == '0) state_reg <= S_CHECK;
          else                   lat_cnt_reg <= lat_cnt_reg - 1'b1;
        end
        S_CHECK:  state_reg <= S_STEP;
        S_RESULT: if (res_ready) begin
          res_valid <= 1'b0;
          state_reg <= S_IDLE;
        end
        default:  state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dda_stepper_v2.sv
// Bench for dda_stepper_v2: three instances (RD_LAT 0, 1, 3) share stimulus and
// an expected-result queue; each instance has its own occupancy model and monitor.
module tb_dda_stepper_v2;
  localparam int W  = 24;
  localparam int IB = 5;
  localparam int SB = 10;
  localparam int NI = 3;

  typedef struct packed {
    logic [2:0]    status;
    logic          hit;
    logic [IB-1:0] hx, hy, hz;
    logic [2:0]    face;
    logic [W-1:0]  t_hit;
    logic [SB-1:0] steps;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          job_valid = 1'b0;
  logic          res_ready = 1'b1;
  logic [IB-1:0] ix0, iy0, iz0;
  logic          sx, sy, sz;
  logic [W-1:0]  nx_i, ny_i, nz_i, inc_x, inc_y, inc_z, t_max;
  logic [SB-1:0] max_steps;
  logic          solid_en = 1'b0;
  logic [3*IB-1:0] solid_addr = '0;

  logic          abort_v     [NI];
  logic          job_ready_w [NI];
  logic          busy_w      [NI];
  logic [3*IB-1:0] addr_w    [NI];
  logic          vs_w        [NI];
  logic          res_valid_w [NI];
  logic          hit_w       [NI];
  logic [IB-1:0] hx_w [NI], hy_w [NI], hz_w [NI];
  logic [2:0]    face_w      [NI];
  logic [W-1:0]  t_hit_w     [NI];
  logic [SB-1:0] steps_w     [NI];
  logic [2:0]    status_w    [NI];
  wire  [31:0]   done_w      [NI];

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  function automatic int lat_of(input int i);
    return (i == 0) ? 0 : ((i == 1) ? 1 : 3);
  endfunction

  function automatic exp_t mk(input int st, input int h, input int x, input int y, input int z,
                              input int f, input int t, input int s);
    exp_t e;
    e.status = 3'(st);  e.hit = 1'(h);
    e.hx = IB'(x);  e.hy = IB'(y);  e.hz = IB'(z);
    e.face = 3'(f);  e.t_hit = W'(t);  e.steps = SB'(s);
    return e;
  endfunction

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int L = (gi == 0) ? 0 : ((gi == 1) ? 1 : 3);
    logic       occ;
    logic [2:0] pipe;
    int         rd_idx = 0;
    int         done_cnt = 0;
    exp_t       e_r;

    assign occ = solid_en && (addr_w[gi] == solid_addr);
    always @(posedge clock or negedge reset_n)
      if (!reset_n) pipe <= '0;
      else          pipe <= {pipe[1:0], occ};
    if (L == 0) begin : g_comb
      assign vs_w[gi] = occ;
    end else begin : g_pipe
      assign vs_w[gi] = pipe[L-1];
    end
    assign done_w[gi] = done_cnt;

    dda_stepper_v2 #(.W(W), .IDX_BITS(IB), .STEP_BITS(SB), .RD_LAT(L), .CHECK_START(1)) u_dut (
      .clock(clock), .reset_n(reset_n), .job_valid(job_valid), .job_ready(job_ready_w[gi]),
      .ix0(ix0), .iy0(iy0), .iz0(iz0), .sx(sx), .sy(sy), .sz(sz),
      .next_x_init(nx_i), .next_y_init(ny_i), .next_z_init(nz_i),
      .inc_x(inc_x), .inc_y(inc_y), .inc_z(inc_z), .t_max(t_max), .max_steps(max_steps),
      .abort(abort_v[gi]), .busy(busy_w[gi]), .voxel_addr(addr_w[gi]), .voxel_solid(vs_w[gi]),
      .res_valid(res_valid_w[gi]), .res_ready(res_ready), .hit(hit_w[gi]),
      .hx(hx_w[gi]), .hy(hy_w[gi]), .hz(hz_w[gi]), .face_id(face_w[gi]),
      .t_hit(t_hit_w[gi]), .steps_taken(steps_w[gi]), .status(status_w[gi])
    );

    always @(negedge clock) begin
      if (reset_n && res_valid_w[gi] && res_ready) begin
        $display("[lat%0d] result %0d: status=%0d hit=%0d pos=(%0d,%0d,%0d) face=%0d t_hit=0x%0h steps=%0d",
                 L, rd_idx, status_w[gi], hit_w[gi], hx_w[gi], hy_w[gi], hz_w[gi],
                 face_w[gi], t_hit_w[gi], steps_w[gi]);
        if (rd_idx >= exp_q.size()) begin
          check($sformatf("lat%0d_unexpected_result", L), 32'd1, 32'd0);
        end else begin
          e_r = exp_q[rd_idx];
          check($sformatf("lat%0d_job%0d_status", L, rd_idx), 32'(status_w[gi]), 32'(e_r.status));
          check($sformatf("lat%0d_job%0d_hit", L, rd_idx),    32'(hit_w[gi]),    32'(e_r.hit));
          check($sformatf("lat%0d_job%0d_hx", L, rd_idx),     32'(hx_w[gi]),     32'(e_r.hx));
          check($sformatf("lat%0d_job%0d_hy", L, rd_idx),     32'(hy_w[gi]),     32'(e_r.hy));
          check($sformatf("lat%0d_job%0d_hz", L, rd_idx),     32'(hz_w[gi]),     32'(e_r.hz));
          check($sformatf("lat%0d_job%0d_face", L, rd_idx),   32'(face_w[gi]),   32'(e_r.face));
          check($sformatf("lat%0d_job%0d_t_hit", L, rd_idx),  32'(t_hit_w[gi]),  32'(e_r.t_hit));
          check($sformatf("lat%0d_job%0d_steps", L, rd_idx),  32'(steps_w[gi]),  32'(e_r.steps));
        end
        rd_idx++;
        done_cnt++;
      end
    end
  end

  task automatic set_defaults();
    ix0 = '0; iy0 = '0; iz0 = '0;
    sx = 1'b1; sy = 1'b1; sz = 1'b1;
    nx_i = 24'h000080; ny_i = 24'hFFFFFF; nz_i = 24'hFFFFFF;
    inc_x = 24'h000100; inc_y = 24'h000100; inc_z = 24'h000100;
    t_max = 24'hFFFFFF; max_steps = 10'd1023;
    solid_en = 1'b0; solid_addr = '0;
    res_ready = 1'b1;
    for (int i = 0; i < NI; i++) abort_v[i] = 1'b0;
  endtask

  task automatic check_reset_vals(input string why);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("%s_lat%0d_res_valid", why, lat_of(i)), 32'(res_valid_w[i]), 32'd0);
      check($sformatf("%s_lat%0d_hit", why, lat_of(i)),       32'(hit_w[i]),       32'd0);
      check($sformatf("%s_lat%0d_pos", why, lat_of(i)),       {17'd0, hz_w[i], hy_w[i], hx_w[i]}, 32'd0);
      check($sformatf("%s_lat%0d_t_hit", why, lat_of(i)),     32'(t_hit_w[i]),     32'd0);
      check($sformatf("%s_lat%0d_steps", why, lat_of(i)),     32'(steps_w[i]),     32'd0);
      check($sformatf("%s_lat%0d_status", why, lat_of(i)),    32'(status_w[i]),    32'd0);
      check($sformatf("%s_lat%0d_busy", why, lat_of(i)),      32'(busy_w[i]),      32'd0);
      check($sformatf("%s_lat%0d_addr", why, lat_of(i)),      32'(addr_w[i]),      32'd0);
      check($sformatf("%s_lat%0d_face", why, lat_of(i)),      32'(face_w[i]),      32'd7);
      check($sformatf("%s_lat%0d_job_ready", why, lat_of(i)), 32'(job_ready_w[i]), 32'd1);
    end
  endtask

  // Cycle k counts from the accepting edge; with the start-voxel test enabled,
  // step n's address phase (ISSUE, or CHECK when RD_LAT=0) begins at cycle n*(RD_LAT+2).
  task automatic launch(input exp_t e, input int abort_n, input bit start_t, input bit hold);
    int base [NI];
    bit all_done, all_valid, finished;
    int hold_cnt, l;
    finished = 1'b0;
    hold_cnt = 0;
    for (int i = 0; i < NI; i++) base[i] = int'(done_w[i]);
    exp_q.push_back(e);
    job_valid = 1'b1;
    @(posedge clock); #1;
    job_valid = 1'b0;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("lat%0d_job_ready_after_accept", lat_of(i)), 32'(job_ready_w[i]), 32'd0);
      check($sformatf("lat%0d_busy_after_accept", lat_of(i)),      32'(busy_w[i]),      32'd1);
    end
    for (int k = 0; k < 4000 && !finished; k++) begin
      all_done  = 1'b1;
      all_valid = 1'b1;
      for (int i = 0; i < NI; i++) begin
        if (int'(done_w[i]) == base[i]) all_done = 1'b0;
        if (!res_valid_w[i]) all_valid = 1'b0;
      end
      if (all_done) begin
        finished = 1'b1;
      end else begin
        if (hold && all_valid && !res_ready) begin
          for (int i = 0; i < NI; i++) begin
            check($sformatf("lat%0d_hold_valid", lat_of(i)),  32'(res_valid_w[i]), 32'd1);
            check($sformatf("lat%0d_hold_status", lat_of(i)), 32'(status_w[i]),    32'(e.status));
            check($sformatf("lat%0d_hold_hx", lat_of(i)),     32'(hx_w[i]),        32'(e.hx));
            check($sformatf("lat%0d_hold_t_hit", lat_of(i)),  32'(t_hit_w[i]),     32'(e.t_hit));
            check($sformatf("lat%0d_hold_steps", lat_of(i)),  32'(steps_w[i]),     32'(e.steps));
          end
          hold_cnt++;
          if (hold_cnt == 5) res_ready = 1'b1;
        end
        for (int i = 0; i < NI; i++) begin
          l = lat_of(i);
          abort_v[i] = (abort_n > 0) && (k == abort_n * (l + 2));
          if (abort_n > 0 && k == abort_n * (l + 2) + 1)
            check($sformatf("lat%0d_abort_latency", l), 32'(res_valid_w[i]), 32'd1);
          if (start_t && k == l)
            check($sformatf("lat%0d_start_latency_early", l), 32'(res_valid_w[i]), 32'd0);
          if (start_t && k == l + 1)
            check($sformatf("lat%0d_start_latency", l), 32'(res_valid_w[i]), 32'd1);
        end
        @(posedge clock); #1;
      end
    end
    for (int i = 0; i < NI; i++) abort_v[i] = 1'b0;
    if (!finished) check("job_timeout", 32'd0, 32'd1);
    repeat (2) begin @(posedge clock); #1; end
    for (int i = 0; i < NI; i++) begin
      check($sformatf("lat%0d_single_result", lat_of(i)), done_w[i] - 32'(base[i]), 32'd1);
      check($sformatf("lat%0d_valid_dropped", lat_of(i)), 32'(res_valid_w[i]), 32'd0);
      check($sformatf("lat%0d_ready_again", lat_of(i)),   32'(job_ready_w[i]), 32'd1);
    end
  endtask

  initial begin
    int base [NI];
    set_defaults();
    repeat (3) @(posedge clock);
    #1;
    check_reset_vals("reset");
    reset_n = 1'b1;
    @(posedge clock); #1;

    // Empty grid: runs off the +X face.
    set_defaults();
    launch(mk(1, 0, 31, 0, 0, 0, 24'h001E80, 31), 0, 1'b0, 1'b0);

    // Solid voxel at (3,0,0).
    set_defaults();
    solid_en = 1'b1; solid_addr = 15'd3;
    launch(mk(0, 1, 3, 0, 0, 0, 24'h000280, 3), 0, 1'b0, 1'b0);

    // Solid start voxel.
    set_defaults();
    solid_en = 1'b1; solid_addr = 15'd0;
    launch(mk(0, 1, 0, 0, 0, 7, 0, 0), 0, 1'b1, 1'b0);

    // Equal timers: X, then Y, then Z.
    set_defaults();
    nx_i = 24'h100; ny_i = 24'h100; nz_i = 24'h100; max_steps = 10'd3;
    launch(mk(2, 0, 1, 1, 1, 4, 24'h000100, 3), 0, 1'b0, 1'b0);

    // t_max cutoff with a held result.
    set_defaults();
    t_max = 24'h000180; res_ready = 1'b0;
    launch(mk(3, 0, 2, 0, 0, 0, 24'h000180, 2), 0, 1'b0, 1'b1);

    // Negative direction leaves through the -X face.
    set_defaults();
    ix0 = 5'd5; iy0 = 5'd5; iz0 = 5'd5; sx = 1'b0;
    launch(mk(1, 0, 0, 5, 5, 1, 24'h000480, 5), 0, 1'b0, 1'b0);

    // Timer saturation: the second X timer pins at all-ones and exceeds t_max.
    set_defaults();
    inc_x = 24'hFFFFF0; t_max = 24'hFFFFFE;
    launch(mk(3, 0, 1, 0, 0, 0, 24'h000080, 1), 0, 1'b0, 1'b0);

    // Zero step budget.
    set_defaults();
    max_steps = 10'd0;
    launch(mk(2, 0, 0, 0, 0, 7, 0, 0), 0, 1'b0, 1'b0);

    // Abort while the address for step 2 is being read.
    set_defaults();
    launch(mk(4, 0, 2, 0, 0, 0, 24'h000180, 2), 2, 1'b0, 1'b0);

    // Reset in the middle of a job.
    set_defaults();
    for (int i = 0; i < NI; i++) base[i] = int'(done_w[i]);
    job_valid = 1'b1;
    @(posedge clock); #1;
    job_valid = 1'b0;
    repeat (10) begin @(posedge clock); #1; end
    reset_n = 1'b0;
    #1;
    check_reset_vals("midjob_reset");
    #10;
    reset_n = 1'b1;
    repeat (50) begin @(posedge clock); #1; end
    for (int i = 0; i < NI; i++) begin
      check($sformatf("lat%0d_no_result_after_reset", lat_of(i)), done_w[i], 32'(base[i]));
      check($sformatf("lat%0d_idle_after_reset", lat_of(i)),      32'(job_ready_w[i]), 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dda_stepper_v2.md
# dda_stepper_v2

Parametrised second-generation 3D DDA voxel traversal engine. It sits between the ray-setup stage, which supplies per-ray DDA parameters, and the voxel occupancy RAM. It walks the grid until it reaches a solid voxel, leaves the grid, exhausts its step budget, passes a distance limit, or is aborted, then returns a registered result.

Additions over the first generation:
- Generic grid, timer and step-counter widths.
- Configurable RAM read latency.
- Optional start-voxel test.
- Ray-length (t_max) cutoff and abort.
- Job handshake with internal parameter latching.
- Registered face and hit-distance outputs.
- 3-bit termination status.

## Interface
Parameters:
- W, 24: unsigned fixed-point timer width.
- IDX_BITS, 5: per-axis index width; grid is 2^IDX_BITS per axis.
- STEP_BITS, 10: step counter / max_steps width.
- RD_LAT, 1: occupancy RAM read latency in cycles, legal 0..3.
- CHECK_START, 1: 1 = test the start voxel before the first step.

Ports:
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- job_valid  in  1  job parameters valid.
- job_ready  out  1  high only in IDLE.
- ix0, iy0, iz0  in  IDX_BITS each  start voxel.
- sx, sy, sz  in  1 each  1 = +direction, 0 = −direction.
- next_x_init, next_y_init, next_z_init  in  W each  initial boundary timers.
- inc_x, inc_y, inc_z  in  W each  per-axis timer increments.
- t_max  in  W  ray length limit.
- max_steps  in  STEP_BITS  step budget.
- abort  in  1  synchronous abort request.
- busy  out  1  high in any state other than IDLE.
- voxel_addr  out  3*IDX_BITS  {iz, iy, ix} of the current position.
- voxel_solid  in  1  occupancy bit, valid RD_LAT cycles after voxel_addr.
- res_valid  out  1  result valid.
- res_ready  in  1  result accepted.
- hit  out  1  solid voxel found.
- hx, hy, hz  out  IDX_BITS each  final voxel position.
- face_id  out  3  0=+X 1=−X 2=+Y 3=−Y 4=+Z 5=−Z 7=none (start voxel).
- t_hit  out  W  timer value at entry to the final voxel.
- steps_taken  out  STEP_BITS  number of steps taken.
- status  out  3  0 HIT, 1 OOB, 2 MAXSTEP, 3 TMAX, 4 ABORT.

## Operation
States: IDLE, STEP, ISSUE, CHECK, RESULT.

- **IDLE:** On job_valid && job_ready, latch all job inputs, set pos = (ix0, iy0, iz0), step_count = 0, t_cur = 0, face = 7. Go to ISSUE if CHECK_START, else STEP.
- **STEP:** Select the axis with the minimum timer; ties resolve X > Y > Z. Evaluate terminations in priority order:
  - step_count == max_steps → RESULT, MAXSTEP.
  - Selected index at 0 with sign − or at 2^IDX_BITS−1 with sign + → RESULT, OOB; position unchanged.
  - Selected timer > t_max → RESULT, TMAX.
  - Otherwise: move index ±1, t_cur = old selected timer, timer += inc with saturation at all-ones, step_count += 1, face = axis/sign code. Go to ISSUE, or to CHECK if RD_LAT == 0.
- **ISSUE:** Hold voxel_addr for RD_LAT cycles using a down-counter, then go to CHECK.
- **CHECK:** Sample voxel_solid. If 1 → RESULT, HIT, hit = 1. If 0 → STEP.
- **RESULT:** All result outputs are registered on entry and held stable while res_valid is high. Leave to IDLE on res_ready. With res_ready held high, back-to-back jobs are possible: job_ready rises the cycle after the handshake.
- **abort:** High in STEP, ISSUE or CHECK → RESULT with status ABORT, hit = 0 and the current position, taking priority over every other condition. Ignored in IDLE and RESULT.
- On miss statuses, hit = 0 and t_hit = t_cur.
- Timer arithmetic is unsigned W-bit. Comparisons are unsigned.

## Timing
- **Reset values:**
  - 0: res_valid, hit, hx, hy, hz, t_hit, steps_taken, status, busy, voxel_addr.
  - face_id = 7.
  - job_ready = 1.
- **Reset mid-job:** reset_n low mid-job discards the job immediately; no result is produced.
- **voxel_addr:** driven combinationally from the position registers, so it changes in the cycle after a STEP update.
- **Cost per empty voxel:** 2 + RD_LAT cycles (STEP + ISSUE×RD_LAT + CHECK).
- **Start-voxel hit:** res_valid rises RD_LAT+1 cycles after the accepting edge.
- **res_valid:** never drops without res_ready; outputs do not change while res_valid && !res_ready.
- **job_ready:** low from the accepting edge until the state returns to IDLE.

## Test plan
Common setup unless stated: RD_LAT=1, origin (0,0,0), sx=sy=sz=1, next_x_init=0x000080, inc_x=0x000100, next_y_init=next_z_init=0xFFFFFF, t_max=0xFFFFFF, max_steps=1023.

- **Empty grid:** → OOB, hx=31, steps_taken=31, face_id=0, hit=0.
- **Solid voxel at (3,0,0):** → HIT, hx=3, steps_taken=3, face_id=0, t_hit=0x000280.
- **Start voxel solid, CHECK_START=1:** → HIT, steps_taken=0, face_id=7, res_valid 2 cycles after acceptance.
- **Tie-break:** next_*_init=0x100, inc_*=0x100, max_steps=3, empty grid → visits (1,0,0), (1,1,0), (1,1,1); MAXSTEP, steps_taken=3.
- **t_max cutoff:** t_max=0x000180, empty grid → TMAX, hx=2, steps_taken=2. Then hold res_ready=0 for 5 cycles → outputs stable, single handshake.
- **Abort and reset:**
  - abort pulse during ISSUE → ABORT next cycle, position preserved.
  - reset_n low mid-job → all outputs at reset values, job_ready=1.
  - Repeat every scenario with RD_LAT=0 and RD_LAT=3; results must be identical.
